// File: rtl/uart_tx.sv
// UART transmitter with a small write FIFO: start + 8 data bits (LSB first) + stop.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx #(
    parameter int Baudrate = 24,
    parameter int Depth    = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Wr_en,
    input  logic [7:0] Data,
    output logic       TX,
    output logic       Busy,
    output logic       Done,
    output logic       Full,
    output logic       Empty
);

    localparam int BW = (Baudrate > 1) ? $clog2(Baudrate) : 1;
    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(Baudrate - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(Depth);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    // ---------------- FIFO ----------------
    logic [7:0]    mem [Depth];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          full_reg, empty_reg;
    logic          push, pop;
    logic [7:0]    head;

    assign push = Wr_en && !full_reg;
    assign head = mem[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (!push && pop)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == DEPTH_C);
            empty_reg <= (count_next == '0);
        end
    end

    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr_reg] <= Data;
    end

    // ---------------- Transmit FSM ----------------
    state_t        state_reg;
    logic [BW-1:0] baud_reg;
    logic [2:0]    bit_reg;
    logic [7:0]    shift_reg;
    logic          tx_reg, busy_reg, done_reg;
    logic          baud_last;
    logic          line_bit;
`ifdef UART_TX_PARITY_EN
    logic          parity_reg;
`endif

    assign baud_last = (baud_reg == BAUD_LAST);
    assign pop = !empty_reg &&
                 ((state_reg == ST_IDLE) || (state_reg == ST_STOP && baud_last));

    // The line level is derived from the current state and then registered,
    // so the serial output trails the FSM by exactly one clock.
    always_comb begin
        line_bit = 1'b1;
        case (state_reg)
            ST_START:  line_bit = 1'b0;
            ST_DATA:   line_bit = shift_reg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: line_bit = parity_reg;
`endif
            default:   line_bit = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg  <= ST_IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            tx_reg   <= line_bit;
            busy_reg <= (state_reg != ST_IDLE);
            done_reg <= (state_reg == ST_STOP) && baud_last;

            if (state_reg == ST_IDLE || baud_last)
                baud_reg <= '0;
            else
                baud_reg <= baud_reg + BW'(1);

            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        shift_reg  <= head;
`ifdef UART_TX_PARITY_EN
                        parity_reg <= ^head;
`endif
                        state_reg  <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        bit_reg   <= '0;
                        state_reg <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        shift_reg <= shift_reg >> 1;
                        bit_reg   <= bit_reg + 3'd1;
                        if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_reg <= ST_PARITY;
`else
                            state_reg <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_last)
                        state_reg <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    if (baud_last) begin
                        // Chain straight into the next frame when data is waiting.
                        if (pop) begin
                            shift_reg  <= head;
`ifdef UART_TX_PARITY_EN
                            parity_reg <= ^head;
`endif
                            state_reg  <= ST_START;
                        end else begin
                            state_reg  <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign TX    = tx_reg;
    assign Busy  = busy_reg;
    assign Done  = done_reg;
    assign Full  = full_reg;
    assign Empty = empty_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed steps plus random traffic checked cycle by cycle
// against a queue-based model of the FIFO and the expected serial line.
module tb_uart_tx;

    localparam int B = 24;
    localparam int D = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx, busy, done, full, empty;

    always #5 clk = ~clk;

    uart_tx #(.Baudrate(B), .Depth(D)) dut (
        .Clk(clk), .Reset(rst_n), .Wr_en(wr_en), .Data(data),
        .TX(tx), .Busy(busy), .Done(done), .Full(full), .Empty(empty)
    );

    int total = 0;
    int bad   = 0;

    // Model: bytes waiting, and the per-clock line levels still to be sent.
    byte unsigned fifo_q[$];
    bit           line_q[$];
    logic         exp_tx = 1'b1, exp_busy = 1'b0, exp_done = 1'b0;
    int           done_seen = 0;
    int           busy_cycles = 0;
    int           exp_frames = 0;

    task automatic check(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, expv, $time);
        end
    endtask

    task automatic push_frame(input byte unsigned b);
        bit p;
        p = ^b;
        repeat (B) line_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            repeat (B) line_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
        repeat (B) line_q.push_back(p);
`endif
        repeat (B) line_q.push_back(1'b1);
    endtask

    // Advance the model by one rising edge, using the inputs the DUT just sampled.
    task automatic model_edge();
        int old_count;
        if (!rst_n) begin
            fifo_q.delete();
            line_q.delete();
            exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
            return;
        end
        exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
        if (line_q.size() > 0) begin
            exp_tx   = line_q.pop_front();
            exp_busy = 1'b1;
            exp_done = (line_q.size() == 0);
            if (exp_done) exp_frames++;
        end
        old_count = fifo_q.size();
        if (line_q.size() == 0 && old_count > 0)
            push_frame(fifo_q.pop_front());
        if (wr_en && old_count < D)
            fifo_q.push_back(data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("tx", tx, exp_tx);
        check("busy", busy, exp_busy);
        check("done", done, exp_done);
        check("full", full, fifo_q.size() == D);
        check("empty", empty, fifo_q.size() == 0);
        if (done === 1'b1) done_seen++;
        if (busy === 1'b1) busy_cycles++;
    endtask

    task automatic write_byte(input byte unsigned b);
        wr_en = 1'b1;
        data  = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((line_q.size() > 0 || fifo_q.size() > 0) && n < 20000) begin
            tick();
            n++;
        end
        check_int("drain_bound", int'(n < 20000), 1);
        repeat (3) tick();
    endtask

    initial begin
        // Reset values
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("reset_tx", tx, 1'b1);
        check("reset_empty", empty, 1'b1);

        // Single byte 0xFE
        done_seen = 0; busy_cycles = 0;
        write_byte(8'hFE);
        tick();
        check("fe_pre_fall", tx, 1'b1);
        tick();
        check("fe_fall", tx, 1'b0);
        drain();
        check_int("fe_done_pulses", done_seen, 1);
        check_int("fe_busy_cycles", busy_cycles, FB * B);
        $display("txn single 0xFE done=%0d busy_cycles=%0d", done_seen, busy_cycles);

        // Fill and overflow
        done_seen = 0; busy_cycles = 0;
        wr_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            data = 8'(i);
            tick();
        end
        check("fill_full", full, 1'b1);
        data = 8'hAA;
        tick();
        wr_en = 1'b0;
        drain();
        check_int("fill_done_pulses", done_seen, 5);
        check_int("fill_busy_cycles", busy_cycles, 5 * FB * B);
        $display("txn fill 0x01..0x05 + dropped 0xAA done=%0d", done_seen);

        // Reset in the middle of the 4th data bit
        write_byte(8'h55);
        write_byte(8'h33);
        repeat (4 * B + 1 + B / 2) tick();
        check("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_tx", tx, 1'b1);
        check("abort_empty", empty, 1'b1);
        check("abort_busy", busy, 1'b0);
        fifo_q.delete();
        line_q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        done_seen = 0;
        repeat (12 * B) tick();
        check_int("abort_no_frame", done_seen, 0);
        $display("txn reset mid-frame, line idle afterwards done=%0d", done_seen);

        // Parity-relevant bytes 0x07 and 0x03 back to back
        write_byte(8'h07);
        write_byte(8'h03);
        drain();
        $display("txn 0x07,0x03 frame_bits=%0d", FB);

        // Random traffic: sparse writes then dense bursts
        done_seen = 0; exp_frames = 0;
        for (int c = 0; c < 4000; c++) begin
            wr_en = (c < 2000) ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 3) != 0);
            data  = 8'($urandom);
            tick();
            if (c == 2999) wr_en = 1'b0;
        end
        wr_en = 1'b0;
        drain();
        check_int("random_frames", done_seen, exp_frames);
        $display("txn random traffic frames=%0d", done_seen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
